decoder_bus_arbiter: RTL and testbench
======================================

Name: decoder_bus_arbiter

Overview:
- Round-robin arbiter that shares one bus/resource among 4 requesters.
- Produces a registered 2-bit grant index plus an enable, which drive the 2-to-4 decoder select/enable inputs directly.
- Also produces a one-hot grant equal to the decoder's intended output.
- Inserts a one-cycle turnaround between owners and can force rotation after a configurable hold limit.

Parameters:
- HOLD_MAX, 16: max OWN cycles before forced release when another requester is waiting. 0 disables the limit. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- req  input  4  request per requester; bit i = requester i; level, held until served
- done  input  1  one-cycle pulse from current owner: transfer finished, release bus
- gnt_idx  output  2  registered index of current/last owner (decoder select)
- gnt_en  output  1  registered; 1 while a requester owns the bus (decoder enable)
- gnt  output  4  registered one-hot grant; equals 1<<gnt_idx when gnt_en=1, else 4'b0000
- busy  output  1  1 in OWN or TURN state
- timeout_evt  output  1  one-cycle pulse: previous owner was forcibly released by HOLD_MAX

Behaviour:
- Reset (rst_n=0 at a rising edge, from any state, including mid-grant):
  - state=IDLE, gnt_idx=2'b00, gnt_en=0, gnt=4'b0000, busy=0, timeout_evt=0.
  - Round-robin pointer ptr=0; hold_cnt=0.
- State IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ... mod 4.
  - Next cycle: state=OWN, gnt_idx=selected, gnt_en=1, gnt one-hot, hold_cnt=0.
  - Latency: req sampled at edge N gives grant visible after edge N+1 (one cycle).
  - If req == 0, stay in IDLE.
- State OWN (owner = gnt_idx):
  - hold_cnt increments each cycle, saturating at 255.
  - Release when any of the following is true:
    - done=1
    - req[owner]=0 (requester withdrew)
    - HOLD_MAX!=0, hold_cnt==HOLD_MAX-1, and (req & ~gnt) != 0
  - On release, next cycle:
    - state=TURN, gnt_en=0, gnt=0, ptr=owner+1 mod 4 (wraps 3 to 0).
    - gnt_idx keeps the old owner value.
  - timeout_evt=1 only in the TURN cycle following a pure HOLD_MAX release.
  - If done or withdrawal coincides with the timeout condition, treat it as a normal release: timeout_evt=0.
  - If the limit is reached and no other requester is waiting, the owner keeps the bus; hold_cnt keeps counting.
- State TURN (exactly one cycle, bus idle):
  - Arbitrate exactly as in IDLE, using the updated ptr.
  - If req != 0, go to OWN with the new grant; otherwise go to IDLE.
  - Minimum gap between consecutive owners: 1 cycle with gnt_en=0.
  - The previous owner is eligible again only if no other requester is set (it is searched last).
- done asserted outside OWN is ignored.
- req changes during TURN/IDLE are sampled only at the arbitration edge; there is no combinational path from inputs to outputs.
- busy = (state==OWN) || (state==TURN).
- Invariants:
  - gnt is always 0 or one-hot.
  - gnt_en=1 implies gnt[gnt_idx]=1.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then req=0000 for 5 cycles -> gnt_en=0, gnt=0000, gnt_idx=00, busy=0 throughout.
- Single requester: req=0100 at edge N; done pulse at N+4 -> gnt=0100 and gnt_idx=10 from N+1; gnt_en=0 at N+5 (TURN); ptr becomes 3.
- Round-robin rotation: req=1111 held, done pulsed each OWN cycle -> owners in order 0,1,2,3,0, separated by one gnt_en=0 cycle each.
- HOLD_MAX=4: requester 1 holds, req=0011 and no done -> release after 4 OWN cycles; timeout_evt=1 in the TURN cycle; requester 0 granted next (ptr wraps 2→3→0). Repeat with req=0010 only -> no release, timeout_evt stays 0.
- Simultaneous events: done=1 in the same cycle as the HOLD_MAX limit -> release with timeout_evt=0. Owner drops req mid-grant -> release the following cycle.
- Reset mid-operation: rst_n=0 while in OWN with gnt=1000 -> next edge gnt=0000, gnt_en=0, gnt_idx=00. With req=1001 after reset -> requester 0 granted first (ptr=0).

Source files
------------

// File: rtl/decoder_bus_arbiter_if.sv
// Bus bundle between the four requesters and the round-robin arbiter.
// The arbiter's grant outputs feed a 2-to-4 decoder: gnt_idx drives the
// select lines, gnt_en drives the enable, and gnt is the decoded result.
interface decoder_bus_arbiter_if;
    logic [3:0] req;          // level request per requester, held until served
    logic       done;         // one-cycle release pulse from the current owner
    logic [1:0] gnt_idx;      // registered owner index (decoder select)
    logic       gnt_en;       // registered owner-valid (decoder enable)
    logic [3:0] gnt;          // registered one-hot grant
    logic       busy;         // bus owned or in turnaround
    logic       timeout_evt;  // pulse: previous owner released by the hold limit

    // Requester side: drives requests and release, observes the grant.
    modport master (
        output req,
        output done,
        input  gnt_idx,
        input  gnt_en,
        input  gnt,
        input  busy,
        input  timeout_evt
    );

    // Arbiter side: samples requests and release, drives the grant.
    modport slave (
        input  req,
        input  done,
        output gnt_idx,
        output gnt_en,
        output gnt,
        output busy,
        output timeout_evt
    );
endinterface

// File: rtl/decoder_bus_arbiter.sv
// Round-robin arbiter sharing one bus among four requesters.
//
// Every output is a register, so nothing combinational reaches the pins from
// req/done. An owner keeps the bus until it pulses done, drops its request,
// or (if HOLD_MAX is non-zero and somebody else is waiting) has held it for
// HOLD_MAX cycles. Each release is followed by exactly one TURN cycle with
// gnt_en low before the next owner is granted. The search pointer moves to
// the slot after the old owner, so the old owner is searched last.
module decoder_bus_arbiter #(
    parameter int unsigned HOLD_MAX = 16   // 0 disables forced rotation; 0..255
) (
    input logic                   clk,
    input logic                   rst_n,   // synchronous, active low
    decoder_bus_arbiter_if.slave  bus
);

    // Last hold_cnt value of an owner's allowed tenure. When the limit is
    // disabled the value is never compared because w_limit_hit is gated.
    localparam logic [7:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);
    localparam logic [7:0] HOLD_SAT  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // bus free, nobody recently released it
        S_OWN  = 2'd1,   // r_gnt_idx owns the bus
        S_TURN = 2'd2    // one dead cycle between owners
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [1:0] r_ptr;          // highest-priority slot for the next search
    logic [7:0] r_hold_cnt;     // completed OWN cycles of the current owner
    logic [1:0] r_gnt_idx;
    logic       r_gnt_en;
    logic [3:0] r_gnt;
    logic       r_busy;
    logic       r_timeout_evt;

    // ------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------
    logic [3:0] w_req_rot;      // requests rotated so r_ptr sits at bit 0
    logic [1:0] w_pick_ofs;     // distance from r_ptr to the winner
    logic [1:0] w_pick_idx;     // absolute index of the winner
    logic       w_pick_found;
    logic       w_owner_req;    // owner is still requesting
    logic       w_others_wait;  // some other requester is waiting
    logic       w_limit_hit;    // hold limit reached with contention
    logic       w_release;      // owner gives up the bus this cycle
    logic       w_timeout;      // release caused by the hold limit alone

    // Round-robin pick: rotate so the pointer slot is lowest, take the
    // lowest set bit, then rotate the offset back into an absolute index.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
        w_pick_ofs   = 2'd0;
        w_req_rot    = 4'(({bus.req, bus.req}) >> r_ptr);
        w_pick_found = |bus.req;
        for (int i = 3; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_pick_ofs = 2'(i);
            end
        end
        w_pick_idx = r_ptr + w_pick_ofs;
    end

    // Release conditions while owning; done/withdrawal take priority over
    // the hold limit when deciding whether this counts as a timeout.
    always_comb begin
        w_owner_req   = bus.req[r_gnt_idx];
        w_others_wait = |(bus.req & ~r_gnt);
        w_limit_hit   = (HOLD_MAX != 0) && (r_hold_cnt == HOLD_LAST) && w_others_wait;
        w_release     = bus.done || !w_owner_req || w_limit_hit;
        w_timeout     = w_limit_hit && !bus.done && w_owner_req;
    end

    // Arbitration FSM with every output registered alongside the state.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, so it sits inside the clocked branch rather than in the sensitivity list.
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= 2'd0;
            r_hold_cnt    <= 8'd0;
            r_gnt_idx     <= 2'd0;
            r_gnt_en      <= 1'b0;
            r_gnt         <= 4'b0000;
            r_busy        <= 1'b0;
            r_timeout_evt <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
            r_timeout_evt <= 1'b0;
            case (r_state)
                S_IDLE, S_TURN: begin
                    if (w_pick_found) begin
                        r_state    <= S_OWN;
                        r_gnt_idx  <= w_pick_idx;
                        r_gnt_en   <= 1'b1;
                        r_gnt      <= 4'b0001 << w_pick_idx;
                        r_busy     <= 1'b1;
                        r_hold_cnt <= 8'd0;
                    end else begin
                        r_state  <= S_IDLE;
                        r_gnt_en <= 1'b0;
                        r_gnt    <= 4'b0000;
                        r_busy   <= 1'b0;
                    end
                end
                S_OWN: begin
                    if (w_release) begin
                        // gnt_idx deliberately keeps the old owner.
                        r_state       <= S_TURN;
                        r_gnt_en      <= 1'b0;
                        r_gnt         <= 4'b0000;
                        r_busy        <= 1'b1;
                        r_ptr         <= r_gnt_idx + 2'd1;
                        r_timeout_evt <= w_timeout;
                    end else if (r_hold_cnt != HOLD_SAT) begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_gnt_en <= 1'b0;
                    r_gnt    <= 4'b0000;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // Drive the interface from the output registers.
    always_comb begin
        bus.gnt_idx     = r_gnt_idx;
        bus.gnt_en      = r_gnt_en;
        bus.gnt         = r_gnt;
        bus.busy        = r_busy;
        bus.timeout_evt = r_timeout_evt;
    end

    // Grant is never more than one-hot, and an enabled grant matches its index.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(r_gnt));
    a_gnt_matches_idx : assert property (@(posedge clk) disable iff (!rst_n)
        r_gnt_en |-> r_gnt[r_gnt_idx]);

endmodule

// File: tb/tb_decoder_bus_arbiter.sv
// Self-checking bench for decoder_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model
// that tracks the owner as an integer and searches requesters in order.
module tb_decoder_bus_arbiter;

    localparam int HOLD_MAX = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    decoder_bus_arbiter_if bus ();

    decoder_bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    int m_owner;   // -1 when nobody owns the bus
    bit m_turn;    // in the dead cycle after a release
    int m_last;    // last granted index (what gnt_idx shows)
    int m_ptr;     // first requester to consider next
    int m_held;    // OWN cycles already completed by the owner
    bit m_tmo;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic d, input logic rn);
        logic [3:0] own_mask;
        bit         lim;
        int         j;
        if (!rn) begin
            m_owner = -1; m_turn = 0; m_last = 0; m_ptr = 0; m_held = 0; m_tmo = 0;
            return;
        end
        m_tmo = 0;
        if (m_owner >= 0) begin
            own_mask = 4'(1 << m_owner);
            lim = (HOLD_MAX != 0) && (m_held == HOLD_MAX - 1) && ((r & ~own_mask) != 4'b0);
            if (d || !r[m_owner] || lim) begin
                m_tmo   = lim && !d && r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_turn  = 1;
            end else begin
                m_held = (m_held < 255) ? m_held + 1 : 255;
            end
        end else begin
            m_turn = 0;
            j = pick(r, m_ptr);
            if (j >= 0) begin
                m_owner = j; m_last = j; m_held = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare at negedge.
    task automatic cyc(input logic [3:0] r, input logic d, input logic rn);
        bus.req  = r;
        bus.done = d;
        rst_n    = rn;
        @(posedge clk);
        model_step(r, d, rn);
        @(negedge clk);
        check("gnt_idx", bus.gnt_idx, 32'(m_last));
        check("gnt_en", bus.gnt_en, 32'(m_owner >= 0));
        check("gnt", bus.gnt, (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
        check("busy", bus.busy, 32'((m_owner >= 0) || m_turn));
        check("timeout_evt", bus.timeout_evt, 32'(m_tmo));
    endtask

    int owners[$];
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    logic [3:0] rnd_req;

    initial begin
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        rst_n    = 1'b0;
        m_owner = -1; m_turn = 0; m_last = 0; m_ptr = 0; m_held = 0; m_tmo = 0;

        // Reset then idle.
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        repeat (5) cyc(4'b0000, 1'b0, 1'b1);
        check("idle_gnt", bus.gnt, 32'h0);
        check("idle_busy", bus.busy, 32'h0);

        // Single requester 2, released by done; pointer moves to 3.
        cyc(4'b0100, 1'b0, 1'b1);
        check("single_gnt", bus.gnt, 32'b0100);
        check("single_idx", bus.gnt_idx, 32'd2);
        repeat (3) cyc(4'b0100, 1'b0, 1'b1);
        cyc(4'b0100, 1'b1, 1'b1);
        check("single_turn_en", bus.gnt_en, 32'd0);
        check("single_turn_idx", bus.gnt_idx, 32'd2);
        check("single_turn_busy", bus.busy, 32'd1);
        cyc(4'b0000, 1'b0, 1'b1);
        check("single_back_idle", bus.busy, 32'd0);
        cyc(4'b1001, 1'b0, 1'b1);
        check("ptr3_gnt", bus.gnt, 32'b1000);

        // Reset in the middle of a grant, then pointer restarts at 0.
        cyc(4'b1001, 1'b0, 1'b1);
        cyc(4'b1001, 1'b0, 1'b0);
        check("midrst_gnt", bus.gnt, 32'h0);
        check("midrst_en", bus.gnt_en, 32'h0);
        check("midrst_idx", bus.gnt_idx, 32'h0);
        cyc(4'b1001, 1'b0, 1'b1);
        check("post_rst_gnt", bus.gnt, 32'b0001);

        // Round-robin rotation with everyone requesting and done held high.
        cyc(4'b0000, 1'b0, 1'b0);
        owners.delete();
        repeat (10) begin
            cyc(4'b1111, 1'b1, 1'b1);
            if (bus.gnt_en) owners.push_back(int'(bus.gnt_idx));
        end
        check("rr_count", 32'(owners.size()), 32'd5);
        for (int i = 0; i < 5 && i < owners.size(); i++)
            check("rr_owner", 32'(owners[i]), 32'(rr_exp[i]));

        // Hold limit with requester 0 waiting: forced release after 4 cycles.
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b1);
        repeat (3) cyc(4'b0011, 1'b0, 1'b1);
        check("hold_still_owner", bus.gnt, 32'b0010);
        cyc(4'b0011, 1'b0, 1'b1);
        check("hold_tmo", bus.timeout_evt, 32'd1);
        check("hold_turn_en", bus.gnt_en, 32'd0);
        cyc(4'b0011, 1'b0, 1'b1);
        check("hold_next_gnt", bus.gnt, 32'b0001);
        check("hold_tmo_pulse", bus.timeout_evt, 32'd0);

        // Hold limit with nobody else waiting: owner keeps the bus.
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b1);
        repeat (10) begin
            cyc(4'b0010, 1'b0, 1'b1);
            check("solo_no_tmo", bus.timeout_evt, 32'd0);
        end
        check("solo_keeps", bus.gnt, 32'b0010);

        // done coincides with the hold limit: ordinary release.
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b1);
        repeat (3) cyc(4'b0011, 1'b0, 1'b1);
        cyc(4'b0011, 1'b1, 1'b1);
        check("coinc_tmo", bus.timeout_evt, 32'd0);
        check("coinc_en", bus.gnt_en, 32'd0);

        // Owner withdraws its request mid-grant.
        cyc(4'b0000, 1'b0, 1'b0);
        cyc(4'b0010, 1'b0, 1'b1);
        cyc(4'b0010, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b1);
        check("withdraw_en", bus.gnt_en, 32'd0);
        check("withdraw_busy", bus.busy, 32'd1);

        // Randomized traffic with sticky requests and occasional resets.
        rnd_req = 4'b0000;
        repeat (3000) begin
            if ($urandom_range(3) == 0) rnd_req = 4'($urandom_range(15));
            cyc(rnd_req, 1'($urandom_range(3) == 0), 1'($urandom_range(63) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
